// File: rtl/wb_pkg.sv
// Shared codes for the writeback stage: write-source selects, load size codes and the
// default datapath width.
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;
  localparam int unsigned CNT_W_DEF = 64;

  typedef enum logic [1:0] {
    WSEL_FLAG = 2'b00,
    WSEL_ALU  = 2'b01,
    WSEL_PC4  = 2'b10,
    WSEL_PASS = 2'b11
  } wsel_e;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  // Low offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      LD_B:    m = 3'b000;
      LD_H:    m = 3'b001;
      LD_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Width in bits of the loaded field; a dword on a 32-bit datapath degrades to a word.
  function automatic logic [6:0] field_bits(input logic [1:0] size, input int unsigned xlen);
    logic [6:0] b;
    case (size)
      LD_B:    b = 7'd8;
      LD_H:    b = 7'd16;
      LD_W:    b = 7'd32;
      default: b = (xlen == 32) ? 7'd32 : 7'd64;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_stage_p_if.sv
// MEM-to-writeback bus: retiring instruction fields in, register-file write port and retire
// status out. master drives the instruction, slave is the writeback stage.
interface wb_stage_p_if
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic             flush;
  logic [RA_W-1:0]  in_rd;
  logic             in_regwrite;
  logic [1:0]       in_wsel;
  logic             in_is_load;
  logic [1:0]       in_ld_size;
  logic             in_ld_uns;
  logic [2:0]       in_addr_lo;
  logic [XLEN-1:0]  in_read_data;
  logic [XLEN-1:0]  in_result;
  logic [XLEN-1:0]  in_pc;
  logic             in_lt;
  logic             in_ltu;

  logic [RA_W-1:0]  rd;
  logic             RegWrite;
  logic [XLEN-1:0]  DataOut_WB;
  logic             misalign;
  logic             retire;
  logic [CNT_W-1:0] instret;

  modport master (
    output in_valid, hold, flush, in_rd, in_regwrite, in_wsel, in_is_load, in_ld_size,
           in_ld_uns, in_addr_lo, in_read_data, in_result, in_pc, in_lt, in_ltu,
    input  in_ready, rd, RegWrite, DataOut_WB, misalign, retire, instret
  );

  modport slave (
    input  in_valid, hold, flush, in_rd, in_regwrite, in_wsel, in_is_load, in_ld_size,
           in_ld_uns, in_addr_lo, in_read_data, in_result, in_pc, in_lt, in_ltu,
    output in_ready, rd, RegWrite, DataOut_WB, misalign, retire, instret
  );

endinterface

// File: rtl/wb_load_ext.sv
// Combinational load extractor: picks the byte/half/word/dword addressed by addr_lo_i out of
// the raw memory word, sign- or zero-extends it, and flags misaligned accesses.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [2:0]      addr_lo_i,
  output logic [XLEN-1:0] ext_o,
  output logic            mis_o
);

  // On a 32-bit datapath only the two low offset bits address a byte within the word.
  localparam logic [2:0] OffMask = 3'(XLEN / 8 - 1);

  logic [1:0]      size_eff;
  logic [2:0]      mask;
  logic [2:0]      off;
  logic [2:0]      field_off;
  logic [6:0]      lsh;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] top_aligned;

  always_comb begin
    size_eff = size_i;
    if (XLEN == 32 && size_i == LD_D) begin
      size_eff = LD_W;
    end
    mask      = align_mask(size_eff);
    off       = addr_lo_i & OffMask;
    mis_o     = (off & mask) != 3'b000;
    field_off = off & ~mask;
    shifted   = data_i >> {field_off, 3'b000};

    // Push the field to the top, then shift back down logically or arithmetically.
    lsh         = 7'(XLEN) - field_bits(size_eff, XLEN);
    top_aligned = shifted << lsh;
    if (uns_i) begin
      ext_o = top_aligned >> lsh;
    end else begin
      ext_o = $unsigned($signed(top_aligned) >>> lsh);
    end
  end

endmodule

// File: rtl/wb_stage_p.sv
// Registered writeback stage between MEM and the register-file write port.
// Optional retire counter is built only when WB_INSTRET_EN is defined.
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic        clk,
  input logic        rst,
  wb_stage_p_if.slave bus
);

  logic [XLEN-1:0]  ld_ext;
  logic             ld_mis;
  logic             mis_in;
  logic [XLEN-1:0]  wdata;
  logic             retire;

  logic             valid_q, valid_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             we_q, we_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] instret_q;

  wb_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .data_i   (bus.in_read_data),
    .size_i   (bus.in_ld_size),
    .uns_i    (bus.in_ld_uns),
    .addr_lo_i(bus.in_addr_lo),
    .ext_o    (ld_ext),
    .mis_o    (ld_mis)
  );

  assign mis_in = bus.in_is_load & ld_mis;

  always_comb begin
    wdata = bus.in_result;
    case (bus.in_wsel)
      WSEL_FLAG: wdata = {{(XLEN-1){1'b0}}, bus.in_lt | bus.in_ltu};
      WSEL_ALU:  wdata = bus.in_is_load ? ld_ext : bus.in_result;
      WSEL_PC4:  wdata = bus.in_pc + XLEN'(4);
      default:   wdata = bus.in_result;
    endcase
  end

  // Flush beats hold, hold beats a new accept; payload only moves on an accept.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    we_d    = we_q;
    mis_d   = mis_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.hold) begin
      valid_d = bus.in_valid;
      if (bus.in_valid) begin
        rd_d   = bus.in_rd;
        data_d = wdata;
        mis_d  = mis_in;
        we_d   = bus.in_regwrite & (bus.in_rd != '0) & ~mis_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
    end
  end

  // An instruction retires in the first cycle it is held with the write port free.
  assign retire = valid_q & ~bus.hold;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_d;

  assign instret_d = instret_q + CNT_W'(retire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end
`else
  assign instret_q = '0;
`endif

  assign bus.in_ready   = ~bus.hold;
  assign bus.rd         = rd_q;
  assign bus.RegWrite   = valid_q & we_q;
  assign bus.DataOut_WB = data_q;
  assign bus.misalign   = valid_q & mis_q & ~bus.hold;
  assign bus.retire     = retire;
  assign bus.instret    = instret_q;

endmodule
